glb_bank_responder: RTL

Bank-side endpoint of the global-buffer packet protocol. Accepts write packets and read-request packets addressed to one GLB bank, executes them on a single-port SRAM macro, and returns read-response packets tagged with the requester's `packet_sel`. Sits between the tile packet router and the bank SRAM wrapper, and answers the initiator-side DMA and processor traffic.

---
 rtl/glb_bank_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/glb_bank_responder.sv
// Bank-side GLB packet endpoint: stages write/read packets, issues them on a single-port SRAM.
// Optional macro GLB_BANK_RD_FWD_EN merges pending-write bytes into read responses.
module glb_bank_responder #(
  parameter int BANK_DATA_WIDTH = 64,
  parameter int BANK_ADDR_WIDTH = 17,
  parameter int GLB_ADDR_WIDTH  = 22
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [1:0]                   wr_sel,
  input  logic [BANK_DATA_WIDTH/8-1:0] wr_strb,
  input  logic [GLB_ADDR_WIDTH-1:0]    wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0]   wr_data,
  input  logic                         rdrq_en,
  input  logic [1:0]                   rdrq_sel,
  input  logic [GLB_ADDR_WIDTH-1:0]    rdrq_addr,
  output logic                         rdrs_data_valid,
  output logic [1:0]                   rdrs_sel,
  output logic [BANK_DATA_WIDTH-1:0]   rdrs_data,
  output logic                         mem_cen,
  output logic                         mem_wen,
  output logic [BANK_ADDR_WIDTH-4:0]   mem_addr,
  output logic [BANK_DATA_WIDTH-1:0]   mem_bit_en,
  output logic [BANK_DATA_WIDTH-1:0]   mem_d,
  input  logic [BANK_DATA_WIDTH-1:0]   mem_q,
  output logic                         wr_overflow
);
  localparam int STRB_WIDTH = BANK_DATA_WIDTH / 8;
  localparam int WORD_WIDTH = BANK_ADDR_WIDTH - 3;

  typedef struct packed {
    logic [STRB_WIDTH-1:0]      strb;
    logic [WORD_WIDTH-1:0]      addr;
    logic [BANK_DATA_WIDTH-1:0] data;
  } wr_pkt_t;

  function automatic logic [BANK_DATA_WIDTH-1:0] strb_to_mask(input logic [STRB_WIDTH-1:0] strb);
    logic [BANK_DATA_WIDTH-1:0] mask;
    for (int i = 0; i < STRB_WIDTH; i++) mask[8*i +: 8] = {8{strb[i]}};
    return mask;
  endfunction

  logic                       s0_wr_valid, s0_rd_valid, pend_valid;
  wr_pkt_t                    s0_wr, pend_wr, issue_wr;
  logic [1:0]                 s0_rd_sel, s1_rd_sel, s2_rd_sel;
  logic [WORD_WIDTH-1:0]      s0_rd_addr;
  logic                       s1_rd_valid, s2_rd_valid;
  logic                       issue_pend, issue_direct, pend_load, pend_drop;
  logic [BANK_DATA_WIDTH-1:0] rd_result;

  // Packet sel of writes and the byte-offset / out-of-bank address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wr_sel, wr_addr[2:0], wr_addr[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH],
                         rdrq_addr[2:0], rdrq_addr[GLB_ADDR_WIDTH-1:BANK_ADDR_WIDTH]};

  // Issue arbitration: staged read first, then the older pending write, then a direct write.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path can infer a latch.
    issue_pend   = 1'b0;
    issue_direct = 1'b0;
    pend_load    = 1'b0;
    pend_drop    = 1'b0;
    if (s0_rd_valid) begin
      pend_load = s0_wr_valid && !pend_valid;
      pend_drop = s0_wr_valid && pend_valid;
    end else if (pend_valid) begin
      issue_pend = 1'b1;
      pend_load  = s0_wr_valid;
    end else begin
      issue_direct = s0_wr_valid;
    end
  end

  assign issue_wr = pend_valid ? pend_wr : s0_wr;

  // NOTE: payload registers have no reset; their valid bits are reset and gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      s0_wr.strb <= wr_strb;
      s0_wr.addr <= wr_addr[BANK_ADDR_WIDTH-1:3];
      s0_wr.data <= wr_data;
    end
    if (rdrq_en) s0_rd_addr <= rdrq_addr[BANK_ADDR_WIDTH-1:3];
    if (pend_load) pend_wr <= s0_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!reset_n) begin
      s0_wr_valid     <= 1'b0;
      s0_rd_valid     <= 1'b0;
      s0_rd_sel       <= 2'd0;
      pend_valid      <= 1'b0;
      wr_overflow     <= 1'b0;
      mem_cen         <= 1'b0;
      mem_wen         <= 1'b0;
      mem_addr        <= '0;
      mem_bit_en      <= '0;
      mem_d           <= '0;
      s1_rd_valid     <= 1'b0;
      s1_rd_sel       <= 2'd0;
      s2_rd_valid     <= 1'b0;
      s2_rd_sel       <= 2'd0;
      rdrs_data_valid <= 1'b0;
      rdrs_sel        <= 2'd0;
      rdrs_data       <= '0;
    end else begin
      s0_wr_valid <= wr_en;
      s0_rd_valid <= rdrq_en;
      if (rdrq_en) s0_rd_sel <= rdrq_sel;

      if (pend_load)       pend_valid <= 1'b1;
      else if (issue_pend) pend_valid <= 1'b0;
      if (pend_drop) wr_overflow <= 1'b1;

      mem_cen <= s0_rd_valid || issue_pend || issue_direct;
      mem_wen <= issue_pend || issue_direct;
      if (s0_rd_valid) begin
        mem_addr   <= s0_rd_addr;
        mem_bit_en <= '1;
      end else if (issue_pend || issue_direct) begin
        mem_addr   <= issue_wr.addr;
        mem_bit_en <= strb_to_mask(issue_wr.strb);
        mem_d      <= issue_wr.data;
      end

      s1_rd_valid     <= s0_rd_valid;
      s1_rd_sel       <= s0_rd_sel;
      s2_rd_valid     <= s1_rd_valid;
      s2_rd_sel       <= s1_rd_sel;
      rdrs_data_valid <= s2_rd_valid;
      if (s2_rd_valid) begin
        rdrs_sel  <= s2_rd_sel;
        rdrs_data <= rd_result;
      end
    end
  end

`ifdef GLB_BANK_RD_FWD_EN
  // The pending write is sampled at read issue; it may drain before mem_q returns.
  logic                       fwd_hit;
  logic [BANK_DATA_WIDTH-1:0] s1_fwd_mask, s1_fwd_data, s2_fwd_mask, s2_fwd_data;

  assign fwd_hit   = s0_rd_valid && pend_valid && (pend_wr.addr == s0_rd_addr);
  assign rd_result = (mem_q & ~s2_fwd_mask) | (s2_fwd_data & s2_fwd_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_fwd_mask <= '0;
      s1_fwd_data <= '0;
      s2_fwd_mask <= '0;
      s2_fwd_data <= '0;
    end else begin
      s1_fwd_mask <= fwd_hit ? strb_to_mask(pend_wr.strb) : '0;
      s1_fwd_data <= pend_wr.data;
      s2_fwd_mask <= s1_fwd_mask;
      s2_fwd_data <= s1_fwd_data;
    end
  end
`else
  assign rd_result = mem_q;
`endif

endmodule
